vlog_param_fifo: RTL and testbench
==================================

Name: vlog_param_fifo

Overview:
Parametrised synchronous FIFO. It extends the fixed 8-bit x 32 memory-array pattern with configurable width, depth, read mode, an almost-full threshold and sticky error flags. It serves as a regression design that exercises unpacked arrays, parameters, functions, for loops, shifts and nonblocking logic under one clock. It sits standalone as a leaf buffer between a producer and a consumer.

Parameters:
WIDTH, 8, data word width in bits (1..64).
DEPTH, 32, entries; power of two, >= 2.
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through.
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush; empties the FIFO and clears the sticky flags
push  input  1  write request
push_data  input  WIDTH  write data
pop  input  1  read request
pop_data  output  WIDTH  read data
pop_valid  output  1  pop_data valid (meaning depends on FWFT)
full  output  1  count == DEPTH
almost_full  output  1  count >= AF_LEVEL
empty  output  1  count == 0
count  output  AW+1  occupancy, AW = clog2(DEPTH)
overflow  output  1  sticky: a push was refused
underflow  output  1  sticky: a pop was refused

Behaviour:
- One clock domain. Reset is asynchronous and active-low: clk and rst_n, with the polarity and synchronicity fixed as stated.
- Reset values: pop_data = 0, pop_valid = 0, full = 0, almost_full = 0 (or 1 if AF_LEVEL == 0), empty = 1, count = 0, overflow = 0, underflow = 0. Memory contents are not reset.
- Pointers: wr_ptr and rd_ptr are AW+1 bits; the MSB is a wrap bit. Address = ptr[AW-1:0]. Increments wrap naturally modulo 2*DEPTH.
  - full = (addresses equal) and (MSBs differ).
  - empty = (pointers equal).
  - count = wr_ptr - rd_ptr, truncated to AW+1 bits.
- A push is accepted when push & (!full | pop_ok), where pop_ok means a pop is accepted in the same cycle.
- A pop is accepted when pop & !empty.
- push & pop when full: both accepted; count unchanged.
- push & pop when empty: push accepted; pop refused and underflow set. In FWFT mode the new word is not visible until the next cycle.
- Refused push (full, no accepted pop): data dropped, overflow <= 1. Refused pop: underflow <= 1. Both flags are sticky until clear or reset.
- FWFT=0 mode:
  - On an accepted pop, pop_data <= mem[rd addr] and pop_valid <= 1 on the next edge.
  - Otherwise pop_valid <= 0 and pop_data holds its value.
  - Latency is 1 cycle from pop to data.
- FWFT=1 mode:
  - pop_data = mem[rd addr] combinationally whenever !empty; pop_valid = !empty.
  - pop consumes the shown word.
  - When empty, pop_data is 0.
- clear has priority over push and pop in the same cycle:
  - Pointers are set to 0 and the sticky flags to 0.
  - pop_valid <= 0.
  - A push in the clear cycle is discarded and does not set overflow.
- All flags and count are registered-pointer derived, so they update the cycle after the event.
- rst_n asserted mid-transfer: every output returns to its reset value immediately; there is no partial write.
- Elaboration check: if DEPTH is not a power of two or AF_LEVEL > DEPTH, the block issues $fatal in an initial block.

Decomposition:
- Package vlog_fifo_pkg holds:
  - constant function clog2(input int n), implemented as a shift loop using >> in a for loop;
  - typedef for the pointer type;
  - localparams FWFT_OFF = 0 and FWFT_ON = 1.
- Sub-module vlog_fifo_mem: simple dual-port array, reg [WIDTH-1:0] mem [DEPTH-1:0], with a write port and an asynchronous read port. The parent adds the output register for FWFT=0.

Test Plan:
1. Reset, WIDTH=8, DEPTH=4, FWFT=0 -> empty=1, count=0, full=0, pop_valid=0, pop_data=0.
2. Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> full=1 and count=4 one cycle after the last push; almost_full=1 from count=2 (AF_LEVEL=2); then pop x4 -> pop_valid pulses with 0x11, 0x22, 0x33, 0x44 each 1 cycle after its pop; empty=1 at the end.
3. FIFO full, push 0x55 with no pop -> overflow=1, count stays 4; next pop returns 0x11. Then push 0x66 & pop together while full -> count stays 4; data out 0x22.
4. Pop when empty -> underflow=1, pop_valid=0; pulse clear -> underflow=0, overflow=0, count=0.
5. FWFT=1: push 0xA5 -> the next cycle pop_valid=1, pop_data=0xA5 without a pop; pop -> empty=1 and pop_data=0 the next cycle.
6. Wrap test: 10 push/pop pairs through DEPTH=4 with data 0..9 -> output order 0..9, count never exceeds 1; assert rst_n low mid-sequence -> count=0 and empty=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vlog_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vlog_fifo_pkg
// Purpose  : Shared constants, pointer type and sizing helper for the FIFO.
// Revision : 1.0
// ============================================================================
package vlog_fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    // Widest pointer (address + wrap bit) the FIFO family supports.
    localparam int PTR_MAX_W = 32;
    typedef logic [PTR_MAX_W-1:0] ptr_max_t;

    // Number of address bits needed for n entries, found by repeated halving.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vlog_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : vlog_fifo_mem
// Purpose  : Simple dual-port storage array, synchronous write, async read.
// Revision : 1.0
// ============================================================================
module vlog_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset; occupancy lives in the pointers.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/vlog_param_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vlog_param_fifo
// Purpose  : Parametrised synchronous FIFO with registered or FWFT read,
//            almost-full threshold and sticky overflow/underflow flags.
// Revision : 1.0
// ============================================================================
module vlog_param_fifo
    import vlog_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int FWFT     = FWFT_OFF,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int             c_aw       = clog2(DEPTH);
    localparam logic [c_aw:0]  c_ptr_one  = (c_aw+1)'(1);
    localparam logic [c_aw:0]  c_af_level = (c_aw+1)'(AF_LEVEL);

    initial begin
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin
            $fatal(1, "vlog_param_fifo: DEPTH must be a power of two >= 2");
        end
        if ((AF_LEVEL > DEPTH) || (AF_LEVEL < 0)) begin
            $fatal(1, "vlog_param_fifo: AF_LEVEL must be within 0..DEPTH");
        end
        if ((c_aw + 1) > PTR_MAX_W) begin
            $fatal(1, "vlog_param_fifo: DEPTH exceeds supported pointer width");
        end
    end

    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_full;
    logic             w_empty;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_rd_data;

    assign w_full    = (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]) &&
                       (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_pop_ok  = pop & ~w_empty;
    assign w_push_ok = push & (~w_full | w_pop_ok);
    // Gating with rst_n and clear keeps a flushed or resetting cycle from writing.
    assign w_wr_en   = w_push_ok & ~clear & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (pop && !w_pop_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

    vlog_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (c_aw)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[c_aw-1:0]),
        .i_wr_data (push_data),
        .i_rd_addr (r_rd_ptr[c_aw-1:0]),
        .o_rd_data (w_rd_data)
    );

    assign full        = w_full;
    assign empty       = w_empty;
    assign count       = r_wr_ptr - r_rd_ptr;
    assign almost_full = (count >= c_af_level);
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

    generate
        if (FWFT == FWFT_ON) begin : g_fwft
            assign pop_valid = ~w_empty;
            assign pop_data  = w_empty ? '0 : w_rd_data;
        end else begin : g_reg_read
            logic [WIDTH-1:0] r_pop_data;
            logic             r_pop_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pop_data  <= '0;
                    r_pop_valid <= 1'b0;
                end else if (clear) begin
                    r_pop_valid <= 1'b0;
                end else begin
                    r_pop_valid <= w_pop_ok;
                    if (w_pop_ok) begin
                        r_pop_data <= w_rd_data;
                    end
                end
            end

            assign pop_valid = r_pop_valid;
            assign pop_data  = r_pop_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vlog_param_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_vlog_param_fifo
// Purpose  : Directed bench for vlog_param_fifo (registered and FWFT reads).
// Revision : 1.0
// ============================================================================
module tb_vlog_param_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Registered-read instance (a_*) and FWFT instance (b_*), both 8 x 4.
    logic       a_clear, a_push, a_pop;
    logic [7:0] a_push_data, a_pop_data;
    logic       a_pop_valid, a_full, a_af, a_empty, a_ovf, a_udf;
    logic [2:0] a_count;

    logic       b_clear, b_push, b_pop;
    logic [7:0] b_push_data, b_pop_data;
    logic       b_pop_valid, b_full, b_af, b_empty, b_ovf, b_udf;
    logic [2:0] b_count;

    vlog_param_fifo #(.WIDTH(8), .DEPTH(4), .FWFT(0), .AF_LEVEL(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .clear(a_clear), .push(a_push),
        .push_data(a_push_data), .pop(a_pop), .pop_data(a_pop_data),
        .pop_valid(a_pop_valid), .full(a_full), .almost_full(a_af),
        .empty(a_empty), .count(a_count), .overflow(a_ovf), .underflow(a_udf)
    );

    vlog_param_fifo #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clear(b_clear), .push(b_push),
        .push_data(b_push_data), .pop(b_pop), .pop_data(b_pop_data),
        .pop_valid(b_pop_valid), .full(b_full), .almost_full(b_af),
        .empty(b_empty), .count(b_count), .overflow(b_ovf), .underflow(b_udf)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       clr;
        logic       psh;
        logic [7:0] d;
        logic       pp;
        logic [2:0] cnt;
        logic       full;
        logic       af;
        logic       emp;
        logic       pv;
        logic [7:0] pd;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vt[$];

    task automatic addv(input logic clr, input logic psh, input logic [7:0] d, input logic pp,
                        input logic [2:0] cnt, input logic full, input logic af, input logic emp,
                        input logic pv, input logic [7:0] pd, input logic ovf, input logic udf);
        vec_t v;
        v = '{clr, psh, d, pp, cnt, full, af, emp, pv, pd, ovf, udf};
        vt.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_clear = 0; a_push = 0; a_pop = 0; a_push_data = 0;
        b_clear = 0; b_push = 0; b_pop = 0; b_push_data = 0;

        //    clr psh d     pp  cnt full af emp pv pd    ovf udf
        addv(0, 1, 8'h11, 0,  1,  0,  0, 0,  0, 8'h00, 0, 0);
        addv(0, 1, 8'h22, 0,  2,  0,  1, 0,  0, 8'h00, 0, 0);
        addv(0, 1, 8'h33, 0,  3,  0,  1, 0,  0, 8'h00, 0, 0);
        addv(0, 1, 8'h44, 0,  4,  1,  1, 0,  0, 8'h00, 0, 0);
        addv(0, 0, 8'h00, 1,  3,  0,  1, 0,  1, 8'h11, 0, 0);
        addv(0, 0, 8'h00, 1,  2,  0,  1, 0,  1, 8'h22, 0, 0);
        addv(0, 0, 8'h00, 1,  1,  0,  0, 0,  1, 8'h33, 0, 0);
        addv(0, 0, 8'h00, 1,  0,  0,  0, 1,  1, 8'h44, 0, 0);
        addv(0, 0, 8'h00, 0,  0,  0,  0, 1,  0, 8'h44, 0, 0);
        addv(0, 1, 8'h11, 0,  1,  0,  0, 0,  0, 8'h44, 0, 0);
        addv(0, 1, 8'h22, 0,  2,  0,  1, 0,  0, 8'h44, 0, 0);
        addv(0, 1, 8'h33, 0,  3,  0,  1, 0,  0, 8'h44, 0, 0);
        addv(0, 1, 8'h44, 0,  4,  1,  1, 0,  0, 8'h44, 0, 0);
        addv(0, 1, 8'h55, 0,  4,  1,  1, 0,  0, 8'h44, 1, 0);
        addv(0, 0, 8'h00, 1,  3,  0,  1, 0,  1, 8'h11, 1, 0);
        addv(0, 1, 8'h55, 0,  4,  1,  1, 0,  0, 8'h11, 1, 0);
        addv(0, 1, 8'h66, 1,  4,  1,  1, 0,  1, 8'h22, 1, 0);
        addv(0, 0, 8'h00, 1,  3,  0,  1, 0,  1, 8'h33, 1, 0);
        addv(0, 0, 8'h00, 1,  2,  0,  1, 0,  1, 8'h44, 1, 0);
        addv(0, 0, 8'h00, 1,  1,  0,  0, 0,  1, 8'h55, 1, 0);
        addv(0, 0, 8'h00, 1,  0,  0,  0, 1,  1, 8'h66, 1, 0);
        addv(0, 0, 8'h00, 1,  0,  0,  0, 1,  0, 8'h66, 1, 1);
        addv(0, 1, 8'h77, 1,  1,  0,  0, 0,  0, 8'h66, 1, 1);
        addv(1, 1, 8'h88, 1,  0,  0,  0, 1,  0, 8'h66, 0, 0);
        addv(0, 0, 8'h00, 1,  0,  0,  0, 1,  0, 8'h66, 0, 1);
        addv(1, 0, 8'h00, 0,  0,  0,  0, 1,  0, 8'h66, 0, 0);

        #12;
        chk("rst a empty", a_empty, 1);
        chk("rst a count", a_count, 0);
        chk("rst a full", a_full, 0);
        chk("rst a almost_full", a_af, 0);
        chk("rst a pop_valid", a_pop_valid, 0);
        chk("rst a pop_data", a_pop_data, 0);
        chk("rst a flags", {a_ovf, a_udf}, 0);
        chk("rst b pop_valid", b_pop_valid, 0);
        chk("rst b pop_data", b_pop_data, 0);
        chk("rst b empty", b_empty, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (vt[i]) begin
            a_clear = vt[i].clr; a_push = vt[i].psh; a_push_data = vt[i].d; a_pop = vt[i].pp;
            tick();
            chk($sformatf("v%0d count", i), a_count, vt[i].cnt);
            chk($sformatf("v%0d full", i), a_full, vt[i].full);
            chk($sformatf("v%0d almost_full", i), a_af, vt[i].af);
            chk($sformatf("v%0d empty", i), a_empty, vt[i].emp);
            chk($sformatf("v%0d pop_valid", i), a_pop_valid, vt[i].pv);
            chk($sformatf("v%0d pop_data", i), a_pop_data, vt[i].pd);
            chk($sformatf("v%0d overflow", i), a_ovf, vt[i].ovf);
            chk($sformatf("v%0d underflow", i), a_udf, vt[i].udf);
        end
        a_clear = 0; a_push = 0; a_pop = 0;

        // Wrap: ten words through a four-entry FIFO, one in and one out per cycle.
        for (int k = 0; k < 10; k++) begin
            a_push = 1; a_push_data = 8'(k); a_pop = (k > 0);
            tick();
            chk($sformatf("wrap%0d count", k), a_count, 1);
            if (k > 0) begin
                chk($sformatf("wrap%0d pop_valid", k), a_pop_valid, 1);
                chk($sformatf("wrap%0d pop_data", k), a_pop_data, k - 1);
            end
        end
        a_push = 0; a_pop = 1;
        tick();
        chk("wrap last pop_data", a_pop_data, 9);
        chk("wrap last empty", a_empty, 1);
        chk("wrap underflow", a_udf, 0);
        a_pop = 0;

        // FWFT instance.
        b_push = 1; b_push_data = 8'hA5;
        #1;
        chk("fwft pre pop_valid", b_pop_valid, 0);
        chk("fwft pre pop_data", b_pop_data, 0);
        tick();
        b_push = 0;
        chk("fwft show pop_valid", b_pop_valid, 1);
        chk("fwft show pop_data", b_pop_data, 8'hA5);
        tick();
        chk("fwft hold pop_data", b_pop_data, 8'hA5);
        b_pop = 1;
        tick();
        b_pop = 0;
        chk("fwft drain empty", b_empty, 1);
        chk("fwft drain pop_data", b_pop_data, 0);
        chk("fwft drain pop_valid", b_pop_valid, 0);
        b_push = 1; b_push_data = 8'hB6; b_pop = 1;
        tick();
        chk("fwft empty pp pop_data", b_pop_data, 8'hB6);
        chk("fwft empty pp underflow", b_udf, 1);
        chk("fwft empty pp count", b_count, 1);
        b_push_data = 8'hC7;
        tick();
        chk("fwft pp pop_data", b_pop_data, 8'hC7);
        chk("fwft pp count", b_count, 1);
        b_push = 0; b_pop = 0;

        // Asynchronous reset in the middle of a transfer.
        a_push = 1; a_push_data = 8'hA1;
        tick();
        a_push_data = 8'hA2;
        tick();
        a_push = 0; a_pop = 1;
        tick();
        chk("pre-rst pop_data", a_pop_data, 8'hA1);
        chk("pre-rst count", a_count, 1);
        a_push = 1; a_push_data = 8'hA3;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst count", a_count, 0);
        chk("async rst empty", a_empty, 1);
        chk("async rst pop_valid", a_pop_valid, 0);
        chk("async rst pop_data", a_pop_data, 0);
        chk("async rst overflow", a_ovf, 0);
        chk("async rst b count", b_count, 0);
        chk("async rst b underflow", b_udf, 0);
        a_push = 0; a_pop = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
